// File: rtl/fib_stream_gen.sv
// Multi-lane Fibonacci-type sequence generator on a valid/ready stream.
// Each beat carries LANES consecutive terms; wrap or saturate-and-stop on overflow.
module fib_stream_gen #(
  parameter int WIDTH    = 16,
  parameter int LANES    = 2,
  parameter int SAT_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       seed_a,
  input  logic [WIDTH-1:0]       seed_b,
  input  logic [15:0]            count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   ovf
);

  localparam logic IDLE   = 1'b0;
  localparam logic RUN    = 1'b1;
  localparam logic SAT_EN = (SAT_MODE != 0);

  logic             state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             wa_q, wa_d;
  logic             wb_q, wb_d;
  logic [15:0]      rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [LANES+1:0][WIDTH-1:0] term_s;
  logic [LANES+1:0]            wrap_s;
  logic [LANES*WIDTH-1:0]      data_s;
  logic                        lane_wrap_s;
  logic                        run_s;
  logic                        hs_s;
  logic                        last_s;

  // Term ladder: t0=a, t1=b, then pairwise sums with the carry kept as that term's wrap flag.
  always_comb begin
    logic [LANES+1:0][WIDTH-1:0] t_v;
    logic [LANES+1:0]            w_v;
    logic [WIDTH:0]              sum_v;
    t_v    = '0;
    w_v    = '0;
    sum_v  = {(WIDTH+1){1'b0}};
    t_v[0] = a_q;
    t_v[1] = b_q;
    w_v[0] = wa_q;
    w_v[1] = wb_q;
    for (int i = 2; i < LANES + 2; i++) begin
      sum_v  = {1'b0, t_v[i-1]} + {1'b0, t_v[i-2]};
      t_v[i] = sum_v[WIDTH-1:0];
      w_v[i] = sum_v[WIDTH];
    end
    term_s = t_v;
    wrap_s = w_v;
  end

  // Lane packing; in saturating mode every lane from the first wrapped one onward clamps.
  always_comb begin
    logic hit_v;
    hit_v  = 1'b0;
    data_s = '0;
    for (int i = 0; i < LANES; i++) begin
      hit_v = hit_v | wrap_s[i];
      if (SAT_EN && hit_v) begin
        data_s[i*WIDTH +: WIDTH] = {WIDTH{1'b1}};
      end else begin
        data_s[i*WIDTH +: WIDTH] = term_s[i];
      end
    end
    lane_wrap_s = hit_v;
  end

  assign run_s  = (state_q == RUN);
  assign hs_s   = run_s & out_ready;
  assign last_s = run_s & ((rem_q == 16'd1) | (SAT_EN & lane_wrap_s));

  // Next-state: load on an accepted start, advance the pair by LANES terms per handshake.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start && (count != 16'd0)) begin
          state_d = RUN;
          a_d     = seed_a;
          b_d     = seed_b;
          wa_d    = 1'b0;
          wb_d    = 1'b0;
          rem_d   = count;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (hs_s) begin
          a_d   = term_s[LANES];
          b_d   = term_s[LANES+1];
          wa_d  = wrap_s[LANES];
          wb_d  = wrap_s[LANES+1];
          rem_d = rem_q - 16'd1;
          if (lane_wrap_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (last_s) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      wa_q    <= 1'b0;
      wb_q    <= 1'b0;
      rem_q   <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = run_s;
  assign busy      = run_s;
  assign out_last  = last_s;
  assign ovf       = ovf_q;
  assign out_data  = run_s ? data_s : {(LANES*WIDTH){1'b0}};

endmodule
